// File: rtl/rv32i_types.sv
// Shared RV32I datapath types.
// Holds the arbiter state encoding used by mem_arbiter; other datapath
// typedefs live alongside it so every stage imports a single package.
package rv32i_types;

  // Memory arbiter FSM: wait for a request, run one memory command for the
  // instruction or data port, then spend one cycle presenting the response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage : rv32i_types

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the instruction-fetch port and the data port onto
// one physical memory port. One access is in flight at a time; requester
// responses and read data are registered, so there is no combinational path
// from the memory side back to the pipeline stall signals.
//
// Ports:
//   clk, rst                 clock (rising edge) / async active-low reset
//   imem_read, imem_address  fetch request, held until imem_resp
//   imem_rdata, imem_resp    fetch data + one-cycle completion
//   dmem_read, dmem_write    data request (write wins if both), held to resp
//   dmem_address, dmem_wdata, dmem_byte_enable   data request payload
//   dmem_rdata, dmem_resp    load data + one-cycle completion
//   pmem_read, pmem_write    memory command, held until pmem_resp
//   pmem_address, pmem_wdata, pmem_byte_enable   latched command payload
//   pmem_rdata, pmem_resp    memory read data + one-cycle completion
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                imem_read,
  input  logic [ADDR_W-1:0]   imem_address,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,

  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [ADDR_W-1:0]   dmem_address,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_byte_enable,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,

  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  logic                last_d_q;     // 1: the most recent grant went to data
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                wr_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                i_resp_q, d_resp_q;

  logic d_req;
  logic pick_d;
  logic grant_i, grant_d;

  // Data wins when it is alone, or on a tie when instruction was served last.
  assign d_req   = dmem_read | dmem_write;
  assign pick_d  = d_req & (~imem_read | ~last_d_q);
  assign grant_d = (state_q == IDLE) & pick_d;
  assign grant_i = (state_q == IDLE) & ~pick_d & imem_read;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = D_BUSY;
        else if (grant_i) state_d = I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;  // requests are ignored for this one cycle
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: the command strobes come only from registered state, so
  // an asynchronous reset drops them immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (state_q == I_BUSY || state_q == D_BUSY) begin
      pmem_read  = ~wr_q;
      pmem_write = wr_q;
    end
  end

  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;
  assign imem_rdata       = i_rdata_q;
  assign imem_resp        = i_resp_q;
  assign dmem_rdata       = d_rdata_q;
  assign dmem_resp        = d_resp_q;

  // ---------------------------------------------------------------------
  // Command registers: captured at grant so later requester changes do not
  // disturb the access in flight.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
    end else if (grant_d) begin
      last_d_q <= 1'b1;
      addr_q   <= dmem_address;
      wdata_q  <= dmem_wdata;
      // Read+write together is a write; reads always fetch the full word.
      be_q     <= dmem_write ? dmem_byte_enable : '1;
      wr_q     <= dmem_write;
    end else if (grant_i) begin
      last_d_q <= 1'b0;
      addr_q   <= imem_address;
      wdata_q  <= '0;
      be_q     <= '1;
      wr_q     <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Response registers: the resp flags are high only in the DONE cycle
  // because they are reloaded every cycle from the busy-state completion.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_resp_q <= (state_q == I_BUSY) & pmem_resp;
      d_resp_q <= (state_q == D_BUSY) & pmem_resp;
      if ((state_q == I_BUSY) && pmem_resp) i_rdata_q <= pmem_rdata;
      if ((state_q == D_BUSY) && pmem_resp) d_rdata_q <= pmem_rdata;
    end
  end

endmodule : mem_arbiter
